// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : processor_pkg
//  Purpose  : Shared opcode/funct encodings and ALU operation type for the
//             single-cycle MIPS-subset processor.
//  Revision : 1.0  initial release
// ============================================================================
package processor_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction bits [5:0])
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_t;

endpackage : processor_pkg
`default_nettype wire

// File: rtl/processor_alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : 32-bit combinational ALU; zero flag drives beq/bne decisions.
//  Revision : 1.0  initial release
// ============================================================================
module alu
    import processor_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select; wrap-around arithmetic, overflow is not reported
    always_comb begin
        result = 32'd0;
        case (alu_op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule : alu
`default_nettype wire

// File: rtl/processor.sv
`default_nettype none
// ============================================================================
//  Module   : processor
//  Purpose  : Single-cycle 32-bit MIPS-subset CPU with private instruction
//             memory, data memory and register file. Every instruction
//             fetches, executes and commits within one clk cycle.
//  Revision : 1.0  initial release
// ============================================================================
module processor
    import processor_pkg::*;
#(
    parameter int IM_WORDS = 32,
    parameter int DM_WORDS = 32
) (
    input  logic clk,
    input  logic reset
);

    localparam int IM_AW = $clog2(IM_WORDS);
    localparam int DM_AW = $clog2(DM_WORDS);

    // Architectural state; names are fixed because benches reach them directly
    logic [31:0] pc;
    logic [31:0] instruc;
    logic [31:0] mem          [0:IM_WORDS-1];
    logic [31:0] datmem       [0:DM_WORDS-1];
    logic [31:0] registerfile [0:31];

    // Instruction fields
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;

    // Decode outputs
    logic        w_reg_we;
    logic        w_dst_rt;
    logic        w_alu_src_imm;
    logic        w_imm_zext;
    alu_op_t     w_alu_op;
    logic        w_mem_we;
    logic        w_mem_to_reg;
    logic        w_beq;
    logic        w_bne;
    logic        w_jump;

    // Datapath
    logic [31:0]     w_rs_val;
    logic [31:0]     w_rt_val;
    logic [31:0]     w_sext;
    logic [31:0]     w_alu_b;
    logic [31:0]     w_alu_result;
    logic            w_alu_zero;
    logic [31:0]     w_ea;
    logic [DM_AW-1:0] w_dm_idx;
    logic [4:0]      w_dst;
    logic [31:0]     w_wb_data;
    logic [31:0]     w_pc_plus4;
    logic [31:0]     w_pc_next;
    logic            w_take_branch;
    logic            w_unused;

    // Fetch: pc is a byte address, the word index wraps with the memory depth
    assign instruc = mem[pc[IM_AW+1:2]];

    assign w_op     = instruc[31:26];
    assign w_rs     = instruc[25:21];
    assign w_rt     = instruc[20:16];
    assign w_rd     = instruc[15:11];
    assign w_funct  = instruc[5:0];
    assign w_imm    = instruc[15:0];
    assign w_target = instruc[25:0];

    // Control decode; anything unrecognised falls through as a NOP
    always_comb begin
        w_reg_we      = 1'b0;
        w_dst_rt      = 1'b0;
        w_alu_src_imm = 1'b0;
        w_imm_zext    = 1'b0;
        w_alu_op      = ALU_ADD;
        w_mem_we      = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_beq         = 1'b0;
        w_bne         = 1'b0;
        w_jump        = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD: begin w_alu_op = ALU_ADD; w_reg_we = 1'b1; end
                    F_SUB: begin w_alu_op = ALU_SUB; w_reg_we = 1'b1; end
                    F_AND: begin w_alu_op = ALU_AND; w_reg_we = 1'b1; end
                    F_OR:  begin w_alu_op = ALU_OR;  w_reg_we = 1'b1; end
                    F_NOR: begin w_alu_op = ALU_NOR; w_reg_we = 1'b1; end
                    F_SLT: begin w_alu_op = ALU_SLT; w_reg_we = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                w_reg_we = 1'b1; w_dst_rt = 1'b1; w_alu_src_imm = 1'b1;
                w_alu_op = ALU_ADD;
            end
            OP_ANDI: begin
                w_reg_we = 1'b1; w_dst_rt = 1'b1; w_alu_src_imm = 1'b1;
                w_imm_zext = 1'b1; w_alu_op = ALU_AND;
            end
            OP_ORI: begin
                w_reg_we = 1'b1; w_dst_rt = 1'b1; w_alu_src_imm = 1'b1;
                w_imm_zext = 1'b1; w_alu_op = ALU_OR;
            end
            OP_LW: begin
                w_reg_we = 1'b1; w_dst_rt = 1'b1; w_alu_src_imm = 1'b1;
                w_mem_to_reg = 1'b1; w_alu_op = ALU_ADD;
            end
            OP_SW: begin
                w_mem_we = 1'b1; w_alu_src_imm = 1'b1; w_alu_op = ALU_ADD;
            end
            OP_BEQ:  begin w_beq = 1'b1; w_alu_op = ALU_SUB; end
            OP_BNE:  begin w_bne = 1'b1; w_alu_op = ALU_SUB; end
            OP_J:    w_jump = 1'b1;
            default: ;
        endcase
    end

    // Register reads: $0 is hardwired to zero regardless of array contents
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : registerfile[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : registerfile[w_rt];

    assign w_sext  = {{16{w_imm[15]}}, w_imm};
    assign w_alu_b = w_alu_src_imm ? (w_imm_zext ? {16'd0, w_imm} : w_sext)
                                   : w_rt_val;

    alu u_alu (
        .a      (w_rs_val),
        .b      (w_alu_b),
        .alu_op (w_alu_op),
        .result (w_alu_result),
        .zero   (w_alu_zero)
    );

    // Effective address shares the ALU adder; byte offset bits are dropped
    assign w_ea      = w_alu_result;
    assign w_dm_idx  = w_ea[DM_AW+1:2];
    assign w_dst     = w_dst_rt ? w_rt : w_rd;
    assign w_wb_data = w_mem_to_reg ? datmem[w_dm_idx] : w_alu_result;

    // Next-pc selection
    assign w_pc_plus4    = pc + 32'd4;
    assign w_take_branch = (w_beq & w_alu_zero) | (w_bne & ~w_alu_zero);
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jump)
            w_pc_next = {w_pc_plus4[31:28], w_target, 2'b00};
        else if (w_take_branch)
            w_pc_next = w_pc_plus4 + {w_sext[29:0], 2'b00};
    end

    // Program counter; reset only clears pc
    always_ff @(posedge clk) begin
        if (reset)
            pc <= 32'd0;
        else
            pc <= w_pc_next;
    end

    // Register writeback; writes to $0 and writes during reset are dropped
    always_ff @(posedge clk) begin
        if (!reset && w_reg_we && (w_dst != 5'd0))
            registerfile[w_dst] <= w_wb_data;
    end

    // Data memory store; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we)
            datmem[w_dm_idx] <= w_rt_val;
    end

    // Fields that carry no meaning for the supported instruction set
    assign w_unused = ^{instruc[10:6], w_ea[31:DM_AW+2], w_ea[1:0]};

endmodule : processor
`default_nettype wire

// File: tb/tb_processor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_processor
//  Purpose  : Directed programs for the single-cycle processor. Stimulus
//             pushes expected architectural state into a queue after each
//             clock; an independent monitor pops and compares on negedge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_processor;

    logic clk;
    logic reset;

    processor #(.IM_WORDS(32), .DM_WORDS(32)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_PC  = 0;
    localparam int K_INS = 1;
    localparam int K_REG = 2;
    localparam int K_DM  = 3;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Instruction encoders
    function automatic logic [31:0] rt_(logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] it_(logic [5:0] op, logic [4:0] rs,
                                        logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jt_(logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            K_PC:    return dut.pc;
            K_INS:   return dut.instruc;
            K_REG:   return dut.registerfile[idx];
            default: return dut.datmem[idx];
        endcase
    endfunction

    task automatic expect_val(int kind, int idx, logic [31:0] v, string n);
        chk_t c;
        c.kind = kind; c.idx = idx; c.exp = v; c.name = n;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) dut.mem[i] = 32'd0;
    endtask

    // Monitor: compare every queued expectation against the settled state
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = q.pop_front();
            act = observe(c.kind, c.idx);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
            end
        end
    end

    logic [31:0] w0;

    initial begin
        reset = 1'b0;

        // ---------------- ALU program ----------------
        clear_mem();
        dut.mem[0]  = it_(6'h08, 0, 1, 16'd5);
        dut.mem[1]  = it_(6'h08, 0, 2, 16'd3);
        dut.mem[2]  = rt_(1, 2, 3, 6'h20);
        dut.mem[3]  = rt_(1, 2, 4, 6'h22);
        dut.mem[4]  = rt_(2, 1, 5, 6'h2A);
        dut.mem[5]  = rt_(0, 0, 6, 6'h27);
        dut.mem[6]  = it_(6'h08, 0, 9, 16'hFFFF);
        dut.mem[7]  = rt_(9, 1, 10, 6'h2A);
        dut.mem[8]  = it_(6'h0D, 0, 11, 16'h8000);
        dut.mem[9]  = it_(6'h08, 0, 12, 16'h8000);
        dut.mem[10] = it_(6'h0C, 12, 13, 16'hFFFF);
        dut.mem[11] = rt_(1, 2, 14, 6'h25);
        dut.mem[12] = rt_(1, 2, 15, 6'h24);
        dut.mem[13] = rt_(2, 2, 2, 6'h20);
        dut.mem[14] = it_(6'h08, 0, 0, 16'd7);
        dut.mem[15] = rt_(0, 0, 16, 6'h20);
        dut.mem[16] = it_(6'h3F, 0, 3, 16'h1234);
        dut.mem[17] = rt_(1, 2, 4, 6'h21);
        dut.mem[18] = 32'd0;
        dut.mem[19] = rt_(1, 1, 3, 6'h20);
        w0 = dut.mem[0];

        do_reset();
        expect_val(K_PC, 0, 32'h0, "reset_pc");
        expect_val(K_INS, 0, w0, "reset_instruc");

        step(); expect_val(K_REG, 1, 32'd5, "addi_r1");
        step(); expect_val(K_REG, 2, 32'd3, "addi_r2");
        step(); expect_val(K_REG, 3, 32'd8, "add_r3");
                expect_val(K_PC, 0, 32'h0C, "pc_after_add");
        step(); expect_val(K_REG, 4, 32'd2, "sub_r4");
        step(); expect_val(K_REG, 5, 32'd1, "slt_r5");
        step(); expect_val(K_REG, 6, 32'hFFFF_FFFF, "nor_r6");
        step(); expect_val(K_REG, 9, 32'hFFFF_FFFF, "addi_neg_r9");
        step(); expect_val(K_REG, 10, 32'd1, "slt_signed_r10");
        step(); expect_val(K_REG, 11, 32'h0000_8000, "ori_zext_r11");
        step(); expect_val(K_REG, 12, 32'hFFFF_8000, "addi_sext_r12");
        step(); expect_val(K_REG, 13, 32'h0000_8000, "andi_zext_r13");
        step(); expect_val(K_REG, 14, 32'd7, "or_r14");
        step(); expect_val(K_REG, 15, 32'd1, "and_r15");
        step(); expect_val(K_REG, 2, 32'd6, "add_self_r2");
        step(); expect_val(K_PC, 0, 32'h3C, "pc_after_addi_r0");
        step(); expect_val(K_REG, 16, 32'd0, "r0_reads_zero");
        step(); expect_val(K_REG, 3, 32'd8, "undef_op_nowrite");
                expect_val(K_PC, 0, 32'h44, "undef_op_pc");
        step(); expect_val(K_REG, 4, 32'd2, "undef_funct_nowrite");
        step(); expect_val(K_PC, 0, 32'h4C, "nop_pc");
        // Reset lands while add $3,$1,$1 is in flight
        do_reset();
        expect_val(K_PC, 0, 32'h0, "midreset_pc");
        expect_val(K_REG, 3, 32'd8, "midreset_r3_kept");
        expect_val(K_REG, 1, 32'd5, "reset_keeps_r1");

        // ---------------- Memory program ----------------
        clear_mem();
        dut.mem[0] = it_(6'h08, 0, 1, 16'd8);
        dut.mem[1] = it_(6'h08, 0, 2, 16'd3);
        dut.mem[2] = it_(6'h2B, 1, 2, 16'd4);
        dut.mem[3] = it_(6'h23, 1, 7, 16'd4);
        dut.mem[4] = it_(6'h08, 0, 20, 16'h55);
        dut.mem[5] = it_(6'h2B, 0, 20, 16'h84);
        dut.mem[6] = it_(6'h23, 0, 21, 16'd4);
        dut.mem[7] = it_(6'h23, 1, 22, 16'd7);
        dut.mem[8] = it_(6'h2B, 0, 20, 16'd12);
        do_reset();
        step(); step();
        step(); expect_val(K_DM, 3, 32'd3, "sw_datmem3");
                expect_val(K_PC, 0, 32'h0C, "sw_pc");
        step(); expect_val(K_REG, 7, 32'd3, "lw_r7");
                expect_val(K_PC, 0, 32'h10, "lw_pc");
        step();
        step(); expect_val(K_DM, 1, 32'h55, "sw_wrap_datmem1");
        step(); expect_val(K_REG, 21, 32'h55, "lw_r21");
        step(); expect_val(K_REG, 22, 32'd3, "lw_low_bits_ignored");
        // Reset lands while sw $20,12($0) is in flight
        do_reset();
        expect_val(K_DM, 3, 32'd3, "midreset_sw_suppressed");
        expect_val(K_PC, 0, 32'h0, "midreset2_pc");

        // ---------------- Branch / jump program ----------------
        clear_mem();
        dut.mem[0] = it_(6'h08, 0, 1, 16'd9);
        dut.mem[4] = it_(6'h04, 1, 1, 16'd2);
        dut.mem[5] = it_(6'h08, 0, 23, 16'd1);
        dut.mem[7] = it_(6'h05, 1, 1, 16'd5);
        dut.mem[8] = jt_(26'd4);
        do_reset();
        step(); step(); step(); step();
        expect_val(K_PC, 0, 32'h10, "pc_at_beq");
        step(); expect_val(K_PC, 0, 32'h1C, "beq_taken");
        step(); expect_val(K_PC, 0, 32'h20, "bne_not_taken");
        step(); expect_val(K_PC, 0, 32'h10, "j_target");

        // ---------------- Wrap program ----------------
        clear_mem();
        dut.mem[0]  = jt_(26'h1F);
        dut.mem[31] = it_(6'h23, 0, 9, 16'h84);
        w0 = dut.mem[0];
        do_reset();
        step(); expect_val(K_PC, 0, 32'h7C, "j_to_7c");
        step(); expect_val(K_PC, 0, 32'h80, "pc_80");
                expect_val(K_INS, 0, w0, "fetch_wrap_mem0");
                expect_val(K_REG, 9, 32'h55, "lw_ea84_datmem1");
                expect_val(K_DM, 3, 32'd3, "datmem_kept_over_reset");

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_processor
`default_nettype wire
